// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the BCD countdown timer and its per-digit decrementor.
//   BCD_W    : bits per BCD digit
//   BCD_MAX  : largest legal BCD digit value
//   state_e  : timer state encoding (IDLE=00, RUN=01, DONE=10)
//   bcd_sat  : clamps an out-of-range digit (A-F) down to 9
// -----------------------------------------------------------------------------
package bcd_pkg;

   localparam int unsigned BCD_W   = 4;
   localparam logic [3:0]  BCD_MAX = 4'd9;

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StRun  = 2'b01,
      StDone = 2'b10
   } state_e;

   // Digits A-F cannot be counted down meaningfully, so they saturate to 9.
   function automatic logic [3:0] bcd_sat(input logic [3:0] i_digit);
      return (i_digit > BCD_MAX) ? BCD_MAX : i_digit;
   endfunction

endpackage

// File: rtl/bcd_decrementor.sv
// -----------------------------------------------------------------------------
// bcd_decrementor
// Combinational single-digit BCD decrement stage with borrow in / borrow out.
// Chained from digit 0 upward to form a multi-digit BCD subtract-by-one.
//   i_in     : current BCD digit
//   i_en     : borrow in; when low the digit passes through unchanged
//   o_out    : resulting BCD digit
//   o_borrow : borrow out to the next more significant digit
// -----------------------------------------------------------------------------
module bcd_decrementor
   import bcd_pkg::*;
(
   input  logic [3:0] i_in,
   input  logic       i_en,
   output logic [3:0] o_out,
   output logic       o_borrow
);

   always_comb begin
      o_out    = i_in;
      o_borrow = 1'b0;
      if (i_en) begin
         if (i_in == 4'd0) begin
            o_out    = BCD_MAX;
            o_borrow = 1'b1;
         end else begin
            o_out = i_in - 4'd1;
         end
      end
   end

endmodule

// File: rtl/bcd_down_counter.sv
// -----------------------------------------------------------------------------
// bcd_down_counter
// Multi-digit BCD countdown timer. Decrements a loaded decimal value on each
// tick while running and pulses o_done when the count reaches zero.
//
// Optional feature: define BCD_DOWN_RELOAD_EN for auto-reload. The last loaded
// value is kept in a reload register and restored instead of reaching zero;
// o_done still pulses once per expiry and the timer stays running.
//
// Ports:
//   i_clk      : clock, rising edge
//   i_reset_n  : synchronous active-low reset
//   i_load     : load i_load_val (digits > 9 clamp to 9), go IDLE
//   i_load_val : BCD value to load, digit 0 in bits [3:0]
//   i_start    : start counting from IDLE
//   i_stop     : abort counting, hold count
//   i_tick     : decrement qualifier (prescaler pulse)
//   o_count    : current BCD count (registered)
//   o_busy     : registered copy of (state == RUN)
//   o_done     : one-cycle completion pulse (registered)
// -----------------------------------------------------------------------------
module bcd_down_counter
   import bcd_pkg::*;
#(
   parameter int unsigned DIGITS = 4
)
(
   input  logic                    i_clk,
   input  logic                    i_reset_n,
   input  logic                    i_load,
   input  logic [4*DIGITS-1:0]     i_load_val,
   input  logic                    i_start,
   input  logic                    i_stop,
   input  logic                    i_tick,
   output logic [4*DIGITS-1:0]     o_count,
   output logic                    o_busy,
   output logic                    o_done
);

   localparam int unsigned CNT_W = BCD_W * DIGITS;

   state_e             r_state;
   logic [CNT_W-1:0]   r_count;
   logic               r_busy;
   logic               r_done;
   // Set on an auto-reload so o_done fires on the following cycle.
   logic               r_pulse;
`ifdef BCD_DOWN_RELOAD_EN
   logic [CNT_W-1:0]   r_reload;
`endif

   logic [CNT_W-1:0]   w_dec;
   logic [DIGITS:0]    w_borrow;
   logic [CNT_W-1:0]   w_load_sat;
   logic               w_is_zero;
   logic               w_is_one;

   // Borrow chain: digit 0 always decrements, higher digits only on borrow.
   assign w_borrow[0] = 1'b1;

   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      bcd_decrementor u_dec (
         .i_in     (r_count[g*BCD_W +: BCD_W]),
         .i_en     (w_borrow[g]),
         .o_out    (w_dec[g*BCD_W +: BCD_W]),
         .o_borrow (w_borrow[g+1])
      );
   end

   // A borrow out of the top digit happens only when every digit is 0.
   assign w_is_zero = w_borrow[DIGITS];
   assign w_is_one  = (r_count == CNT_W'(1));

   always_comb begin
      w_load_sat = '0;
      for (int i = 0; i < DIGITS; i++) begin
         w_load_sat[i*BCD_W +: BCD_W] = bcd_sat(i_load_val[i*BCD_W +: BCD_W]);
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_state  <= StIdle;
         r_count  <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_pulse  <= 1'b0;
`ifdef BCD_DOWN_RELOAD_EN
         r_reload <= '0;
`endif
      end else begin
         // Outputs are registered copies of the state held during this cycle.
         r_busy  <= (r_state == StRun);
         r_done  <= (r_state == StDone) || r_pulse;
         r_pulse <= 1'b0;

         if (i_load) begin
            r_count  <= w_load_sat;
`ifdef BCD_DOWN_RELOAD_EN
            r_reload <= w_load_sat;
`endif
            r_state  <= StIdle;
            r_done   <= 1'b0;
         end else begin
            case (r_state)
               StIdle: begin
                  if (i_start) begin
                     r_state <= w_is_zero ? StDone : StRun;
                  end
               end
               StRun: begin
                  if (i_stop) begin
                     r_state <= StIdle;
                  end else if (i_tick) begin
                     if (w_is_one) begin
`ifdef BCD_DOWN_RELOAD_EN
                        if (r_reload != '0) begin
                           r_count <= r_reload;
                           r_pulse <= 1'b1;
                        end else begin
                           r_count <= '0;
                           r_state <= StDone;
                        end
`else
                        r_count <= '0;
                        r_state <= StDone;
`endif
                     end else begin
                        r_count <= w_dec;
                     end
                  end
               end
               StDone: begin
                  r_state <= StIdle;
               end
               default: begin
                  r_state <= StIdle;
               end
            endcase
         end
      end
   end

   assign o_count = r_count;
   assign o_busy  = r_busy;
   assign o_done  = r_done;

endmodule

// File: tb/tb_bcd_down_counter.sv
// -----------------------------------------------------------------------------
// tb_bcd_down_counter
// Directed steps followed by random stimulus, checked every cycle against a
// decimal-integer model of the countdown timer.
// -----------------------------------------------------------------------------
module tb_bcd_down_counter;

   localparam int unsigned DIGITS = 4;
`ifdef BCD_DOWN_RELOAD_EN
   localparam bit RELOAD = 1'b1;
`else
   localparam bit RELOAD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n, ld, st, sp, tk;
   logic [15:0] lv;
   logic [15:0] count;
   logic        busy, done;

   always #5 clk = ~clk;

   bcd_down_counter #(.DIGITS(DIGITS)) dut (
      .i_clk      (clk),
      .i_reset_n  (rst_n),
      .i_load     (ld),
      .i_load_val (lv),
      .i_start    (st),
      .i_stop     (sp),
      .i_tick     (tk),
      .o_count    (count),
      .o_busy     (busy),
      .o_done     (done)
   );

   // Model state: count as a plain decimal integer.
   int    m_val, m_reload;
   bit    m_run, m_fin, m_pulse, m_busy, m_done;
   int    n_checks = 0;
   int    n_pass   = 0;
   string phase    = "init";

   function automatic int sat_val(input logic [15:0] v);
      int r = 0;
      int m = 1;
      for (int i = 0; i < 4; i++) begin
         int d = int'(v[i*4 +: 4]);
         if (d > 9) d = 9;
         r += d * m;
         m *= 10;
      end
      return r;
   endfunction

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      int x = v;
      for (int i = 0; i < 4; i++) begin
         r[i*4 +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
   endtask

   // Advance the model by one clock edge using the currently driven inputs.
   task automatic model_edge();
      bit nb, nd, np;
      if (!rst_n) begin
         m_val = 0; m_reload = 0;
         m_run = 0; m_fin = 0; m_pulse = 0; m_busy = 0; m_done = 0;
         return;
      end
      nb = m_run;
      nd = m_fin || m_pulse;
      np = 1'b0;
      if (ld) begin
         m_val    = sat_val(lv);
         m_reload = m_val;
         m_run    = 0;
         m_fin    = 0;
         nd       = 0;
      end else if (m_run) begin
         if (sp) begin
            m_run = 0;
         end else if (tk) begin
            if (m_val == 1) begin
               if (RELOAD && m_reload != 0) begin
                  m_val = m_reload;
                  np    = 1;
               end else begin
                  m_val = 0;
                  m_run = 0;
                  m_fin = 1;
               end
            end else begin
               m_val = m_val - 1;
            end
         end
      end else if (m_fin) begin
         m_fin = 0;
      end else if (st) begin
         if (m_val == 0) m_fin = 1;
         else            m_run = 1;
      end
      m_busy  = nb;
      m_done  = nd;
      m_pulse = np;
   endtask

   task automatic step(input bit r, input bit l, input logic [15:0] v,
                       input bit s, input bit p, input bit t);
      rst_n = r; ld = l; lv = v; st = s; sp = p; tk = t;
      @(posedge clk);
      model_edge();
      #1;
      check("count", count, to_bcd(m_val));
      check("busy", 16'(busy), 16'(m_busy));
      check("done", 16'(done), 16'(m_done));
   endtask

   int done_cnt;

   initial begin
      rst_n = 0; ld = 1; lv = 16'h1234; st = 0; sp = 0; tk = 0;

      phase = "reset";
      step(0, 1, 16'h1234, 0, 0, 0);
      step(0, 1, 16'h1234, 0, 0, 0);
      check("rst_count", count, 16'h0000);
      check("rst_busy", 16'(busy), 16'h0);
      check("rst_done", 16'(done), 16'h0);

      phase = "borrow";
      step(1, 1, 16'h0100, 0, 0, 0);
      step(1, 0, 16'h0000, 1, 0, 0);
      step(1, 0, 16'h0000, 0, 0, 1);
      check("b1", count, 16'h0099);
      check("b1_busy", 16'(busy), 16'h1);
      step(1, 0, 16'h0000, 0, 0, 1);
      check("b2", count, 16'h0098);
      check("b2_busy", 16'(busy), 16'h1);
      step(1, 0, 16'h0000, 0, 1, 0);
      step(1, 0, 16'h0000, 0, 0, 0);

      phase = "terminal";
      step(1, 1, 16'h0003, 0, 0, 0);
      step(1, 0, 16'h0000, 1, 0, 1);
      step(1, 0, 16'h0000, 0, 0, 1);
      check("t2", count, 16'h0002);
      step(1, 0, 16'h0000, 0, 0, 1);
      check("t1", count, 16'h0001);
      step(1, 0, 16'h0000, 0, 0, 1);
`ifndef BCD_DOWN_RELOAD_EN
      check("t0", count, 16'h0000);
      check("t0_done_low", 16'(done), 16'h0);
      step(1, 0, 16'h0000, 0, 0, 1);
      check("t_done", 16'(done), 16'h1);
      check("t_busy_drop", 16'(busy), 16'h0);
      step(1, 0, 16'h0000, 0, 0, 1);
      check("t_done_end", 16'(done), 16'h0);
      check("t_idle_hold", count, 16'h0000);
`endif
      step(1, 0, 16'h0000, 0, 1, 0);
      step(1, 0, 16'h0000, 0, 0, 0);

      phase = "sanitize";
      step(1, 1, 16'h0A5F, 0, 0, 0);
      check("sat", count, 16'h0959);
      step(1, 1, 16'h0000, 0, 0, 0);
      step(1, 0, 16'h0000, 1, 0, 0);
      check("z_nodone_yet", 16'(done), 16'h0);
      step(1, 0, 16'h0000, 0, 0, 0);
      check("z_done", 16'(done), 16'h1);
      check("z_busy", 16'(busy), 16'h0);
      step(1, 0, 16'h0000, 0, 0, 0);
      check("z_done_end", 16'(done), 16'h0);

      phase = "stop";
      step(1, 1, 16'h0050, 0, 0, 0);
      step(1, 0, 16'h0000, 1, 0, 0);
      for (int i = 0; i < 3; i++) step(1, 0, 16'h0000, 0, 0, 1);
      check("s47", count, 16'h0047);
      step(1, 0, 16'h0000, 0, 1, 1);
      check("s_hold", count, 16'h0047);
      step(1, 0, 16'h0000, 0, 0, 1);
      check("s_hold2", count, 16'h0047);
      check("s_busy", 16'(busy), 16'h0);
      check("s_nodone", 16'(done), 16'h0);
      step(1, 1, 16'h0321, 0, 1, 0);
      check("s_loadwins", count, 16'h0321);

`ifdef BCD_DOWN_RELOAD_EN
      phase = "reload";
      step(1, 1, 16'h0002, 0, 0, 0);
      step(1, 0, 16'h0000, 1, 0, 0);
      done_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         step(1, 0, 16'h0000, 0, 0, 1);
         check("r_seq", count, (i % 2 == 0) ? 16'h0001 : 16'h0002);
         check("r_busy", 16'(busy), 16'h1);
         if (done) done_cnt++;
      end
      step(1, 0, 16'h0000, 0, 0, 0);
      if (done) done_cnt++;
      check("r_pulses", 16'(done_cnt), 16'd3);
      step(1, 0, 16'h0000, 0, 1, 0);
`endif

      phase = "random";
      for (int i = 0; i < 600; i++) begin
         logic [15:0] v;
         v = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom & 32'h0000_001F);
         step(($urandom_range(0, 99) != 0),
              ($urandom_range(0, 19) == 0),
              v,
              ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 29) == 0),
              ($urandom_range(0, 1) == 1));
      end

      phase = "midrun_reset";
      step(1, 1, 16'h0020, 0, 0, 0);
      step(1, 0, 16'h0000, 1, 0, 0);
      step(1, 0, 16'h0000, 0, 0, 1);
      step(0, 0, 16'h0000, 0, 0, 1);
      check("mr_count", count, 16'h0000);
      check("mr_busy", 16'(busy), 16'h0);
      check("mr_done", 16'(done), 16'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/bcd_down_counter.md
Name: bcd_down_counter

Overview:
- Multi-digit BCD countdown timer.
- Decrements a loaded decimal value by one on each qualified tick and signals completion when it reaches zero.
- Counterpart of the team's BCD increment logic: borrow chain instead of carry chain.
- Used for seven-segment countdown displays and decimal timeouts, driven by a prescaled tick.

Parameters:
DIGITS, 4, number of BCD digits; count width is 4*DIGITS bits, digit 0 in bits [3:0].

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  synchronous active-low reset
load  input  1  load load_val into count; highest priority after reset
load_val  input  4*DIGITS  BCD value to load
start  input  1  begin counting from IDLE
stop  input  1  abort counting, hold current count
tick  input  1  decrement qualifier, 1-cycle pulse from prescaler
count  output  4*DIGITS  current BCD value (registered)
busy  output  1  high while state is RUN
done  output  1  one-cycle completion pulse (registered)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on reset_n, sampled on the rising edge of clk.
- Reset values: count = 0, state = IDLE, busy = 0, done = 0, reload register = 0.
- States:
  - IDLE: holds count.
  - RUN: decrements on tick.
  - DONE: lasts exactly one cycle, drives done = 1, then returns to IDLE.
- Priority per cycle: reset_n low > load > stop > start/tick.
- load (any state):
  - count <= load_val, sanitized per digit: any digit > 9 is stored as 9.
  - Reload register <= the same sanitized value.
  - state <= IDLE; done forced 0 that cycle.
- stop in RUN: state <= IDLE, count unchanged, no done pulse. stop in IDLE or DONE: no effect.
- start in IDLE:
  - count != 0: state <= RUN next cycle. The first decrement happens on the first tick seen in RUN, never in the start cycle.
  - count == 0: state <= DONE, so done is high the following cycle.
- start in RUN: ignored.
- RUN with tick = 1: count <= count - 1 in BCD.
  - Per digit: 0 becomes 9 with a borrow; otherwise the digit minus 1 with no borrow.
  - The borrow ripples from digit 0 upward; a digit changes only when the borrow into it is 1.
- RUN with tick = 0: count held.
- Terminal: tick in RUN while count == 1 gives count <= 0 and state <= DONE. done = 1 in the next cycle only, then IDLE.
- busy = (state == RUN), registered.
- Latency: count updates one cycle after the qualifying tick edge; done follows the count-reaching-zero update by exactly 1 cycle.
- Reset mid-RUN: all outputs go to reset values the next edge; no done pulse.

Optional Feature:
- Macro: BCD_DOWN_RELOAD_EN.
- Defined (auto-reload):
  - Tick at count == 1 in RUN: count <= reload register, state stays RUN, done pulses high for one cycle (next cycle).
  - If the reload register is 0, behaviour is as without the macro.
  - stop still exits to IDLE.
- Undefined: single-shot as described above. Reload register and its logic are not synthesized; load only writes count.

Decomposition:
- Shared package bcd_pkg:
  - BCD digit width constant (4).
  - Max digit constant (9).
  - State typedef/encoding for IDLE/RUN/DONE (2 bits: 00/01/10).
- Sub-module bcd_decrementor: combinational, one digit.
  - Ports: in[3:0], en (borrow in), out[3:0], borrow.
  - Rules: en = 0 passes in through with borrow 0; in == 0 with en = 1 gives out 9, borrow 1; otherwise out = in - 1, borrow 0.
  - Instantiated DIGITS times in a generate chain.

Test Plan:
- Reset: hold reset_n = 0 for 2 cycles with load = 1 asserted -> count = 0x0000, busy = 0, done = 0.
- Basic borrow: load 0x0100, start, 1 tick -> count = 0x0099; next tick -> 0x0098; busy = 1 throughout.
- Terminal: load 0x0003, start, tick every cycle -> count 2, 1, 0; done high exactly one cycle after count = 0; busy drops the same cycle done rises; state returns to IDLE.
- Sanitize and zero-start: load 0x0A5F -> count = 0x0959. Then load 0x0000 and start -> done pulses next cycle, busy never asserted.
- Stop and priority: load 0x0050, start, 3 ticks -> 0x0047. Assert stop and tick together -> count stays 0x0047, busy = 0, no done. Then load and stop together -> load wins, count = load_val.
- With BCD_DOWN_RELOAD_EN: load 0x0002, start, 6 ticks -> count sequence 1, 0x0002, 1, 0x0002, 1, 0x0002; done pulses 3 times; busy stays 1.
